serial_remainder_mod_n_fsm: RTL and testbench

Parametrised successor to the fixed divide-by-3/divide-by-5 serial FSMs. It accepts a binary number one bit per valid cycle, framed by start/last markers, and tracks the running remainder modulo a compile-time divisor `DIVISOR`. It reports live divisibility and, at frame end, a one-cycle result strobe with the held final remainder. It sits after serial-input deserialisers and checksum front-ends that need mod-N residues.

---
 rtl/serial_mod_pkg.sv | 54 +++++
 rtl/serial_mod_step.sv | 65 ++++++
 rtl/serial_remainder_mod_n_fsm.sv | 110 +++++++++++
 tb/tb_serial_remainder_mod_n_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_mod_pkg
// Description : Shared constants, types and helpers for the serial mod-N
//               remainder tracker. Selects the bit order at build time:
//               define SERIAL_MOD_LSB_FIRST_EN for LSB-first framing,
//               leave it undefined for MSB-first framing.
// Revision    : 1.0  initial release
// ============================================================================
package serial_mod_pkg;

    // Legal divisor range for the remainder tracker.
    localparam int MIN_DIVISOR = 2;
    localparam int MAX_DIVISOR = 256;

    // Widest remainder any legal divisor can need.
    localparam int MAX_RW = $clog2(MAX_DIVISOR);

    // One bit wider than the widest remainder so that N itself and any
    // residue fit; this is the working width of mod_add.
    typedef logic [MAX_RW:0] mod_word_t;

    // Order in which the serial bits of a number arrive.
    typedef enum logic {
        BIT_ORDER_MSB_FIRST = 1'b0,
        BIT_ORDER_LSB_FIRST = 1'b1
    } bit_order_e;

`ifdef SERIAL_MOD_LSB_FIRST_EN
    localparam bit_order_e BIT_ORDER = BIT_ORDER_LSB_FIRST;
`else
    localparam bit_order_e BIT_ORDER = BIT_ORDER_MSB_FIRST;
`endif

    // Remainder width needed to hold residues 0..divisor-1.
    function automatic int rem_width(input int divisor);
        return $clog2(divisor);
    endfunction

    // (a + b) mod n for a, b < n: the sum is below 2n, so one
    // conditional subtract fully reduces it.
    function automatic mod_word_t mod_add(input mod_word_t a,
                                          input mod_word_t b,
                                          input mod_word_t n);
        logic [MAX_RW+1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, n}) begin
            sum = sum - {1'b0, n};
        end
        return sum[MAX_RW:0];
    endfunction

endpackage : serial_mod_pkg
`default_nettype wire

// File: rtl/serial_mod_step.sv
`default_nettype none
// ============================================================================
// Module      : serial_mod_step
// Description : Combinational next-state logic of the mod-N remainder FSM.
//               MSB-first: r' = (2r + b) mod N.
//               LSB-first (SERIAL_MOD_LSB_FIRST_EN): r' = (r + b*w) mod N,
//               w' = 2w mod N. A start bit treats the prior state as r = 0
//               (and w = 1), so the first bit of a frame yields r' = b.
// Revision    : 1.0  initial release
// ============================================================================
module serial_mod_step
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR = 5,
    parameter int RW      = $clog2(DIVISOR)
) (
    input  logic [RW-1:0] cur_rem,
    input  logic [RW-1:0] cur_weight,
    input  logic          start,
    input  logic          new_bit,
    output logic [RW-1:0] next_rem,
    output logic [RW-1:0] next_weight
);

    logic [RW-1:0] base_rem;

    // A start bit discards the running residue of the previous frame.
    always_comb begin
        base_rem = start ? '0 : cur_rem;
    end

    generate
        if (BIT_ORDER == BIT_ORDER_LSB_FIRST) begin : g_lsb_first
            logic [RW-1:0] base_weight;
            logic [RW-1:0] addend;

            // Add this bit's weight into the residue, then double the weight.
            always_comb begin
                base_weight = start ? RW'(1) : cur_weight;
                addend      = new_bit ? base_weight : '0;
                next_rem    = RW'(mod_add(mod_word_t'(base_rem),
                                          mod_word_t'(addend),
                                          mod_word_t'(DIVISOR)));
                next_weight = RW'(mod_add(mod_word_t'(base_weight),
                                          mod_word_t'(base_weight),
                                          mod_word_t'(DIVISOR)));
            end
        end else begin : g_msb_first
            // N always fits in RW+1 bits because N <= 2^RW.
            localparam logic [RW:0] N_EXT = (RW+1)'(DIVISOR);
            logic [RW:0] doubled;

            // Shift the new bit in and fold back with one subtract; weight
            // has no role in this order and simply holds its value.
            always_comb begin
                doubled     = {base_rem, new_bit};
                next_rem    = (doubled >= N_EXT) ? RW'(doubled - N_EXT)
                                                 : RW'(doubled);
                next_weight = cur_weight;
            end
        end
    endgenerate

endmodule : serial_mod_step
`default_nettype wire

// File: rtl/serial_remainder_mod_n_fsm.sv
`default_nettype none
// ============================================================================
// Module      : serial_remainder_mod_n_fsm
// Description : Serial mod-DIVISOR remainder tracker. Accepts one bit per
//               valid cycle framed by in_start/in_last, keeps the running
//               residue (the FSM state, encoded as the residue value), and
//               on frame end captures the final residue with a one-cycle
//               done strobe. Bit order is MSB-first unless the build macro
//               SERIAL_MOD_LSB_FIRST_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module serial_remainder_mod_n_fsm
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR = 5,
    parameter int RW      = $clog2(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_start,
    input  logic          in_last,
    input  logic          new_bit,
    output logic [RW-1:0] remainder,
    output logic          div_by_n,
    output logic          done,
    output logic [RW-1:0] result_rem,
    output logic          result_div
);

    // Reject unsupported divisors and an overridden remainder width.
    generate
        if (DIVISOR < MIN_DIVISOR || DIVISOR > MAX_DIVISOR) begin : g_bad_divisor
            $error("serial_remainder_mod_n_fsm: DIVISOR %0d outside 2..256", DIVISOR);
        end
        if (RW != rem_width(DIVISOR)) begin : g_bad_rw
            $error("serial_remainder_mod_n_fsm: RW must equal $clog2(DIVISOR)");
        end
    endgenerate

    localparam logic [RW-1:0] WEIGHT_RESET = RW'(1);

    logic [RW-1:0] remainder_q,  remainder_d;
    logic [RW-1:0] weight_q,     weight_d;
    logic          done_q,       done_d;
    logic [RW-1:0] result_rem_q, result_rem_d;
    logic          result_div_q, result_div_d;

    logic [RW-1:0] step_rem;
    logic [RW-1:0] step_weight;

    serial_mod_step #(
        .DIVISOR (DIVISOR),
        .RW      (RW)
    ) u_step (
        .cur_rem     (remainder_q),
        .cur_weight  (weight_q),
        .start       (in_start),
        .new_bit     (new_bit),
        .next_rem    (step_rem),
        .next_weight (step_weight)
    );

    // Advance on accepted bits only; a last bit also latches the result
    // and arms the done strobe for the following cycle.
    always_comb begin
        remainder_d  = remainder_q;
        weight_d     = weight_q;
        done_d       = 1'b0;
        result_rem_d = result_rem_q;
        result_div_d = result_div_q;
        if (in_valid) begin
            remainder_d = step_rem;
            weight_d    = step_weight;
            if (in_last) begin
                result_rem_d = step_rem;
                result_div_d = (step_rem == '0);
                done_d       = 1'b1;
            end
        end
    end

    // All state clears the instant rst rises, including an in-flight done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remainder_q  <= '0;
            weight_q     <= WEIGHT_RESET;
            done_q       <= 1'b0;
            result_rem_q <= '0;
            result_div_q <= 1'b1;
        end else begin
            remainder_q  <= remainder_d;
            weight_q     <= weight_d;
            done_q       <= done_d;
            result_rem_q <= result_rem_d;
            result_div_q <= result_div_d;
        end
    end

    // Outputs come straight from the registers; div_by_n decodes the state.
    always_comb begin
        remainder  = remainder_q;
        div_by_n   = (remainder_q == '0);
        done       = done_q;
        result_rem = result_rem_q;
        result_div = result_div_q;
    end

endmodule : serial_remainder_mod_n_fsm
`default_nettype wire

// File: tb/tb_serial_remainder_mod_n_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_remainder_mod_n_fsm
// Description : Self-checking bench for serial_remainder_mod_n_fsm. Drives one
//               shared serial stream into instances with several divisors and
//               compares every instance against an arithmetic model of the
//               framed number. Honours SERIAL_MOD_LSB_FIRST_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_remainder_mod_n_fsm;

    localparam int NDUT = 7;
    localparam int I2 = 0, I3 = 1, I5 = 2, I6 = 3, I7 = 4;

`ifdef SERIAL_MOD_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    function automatic int div_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 5;
            3:       return 6;
            4:       return 7;
            5:       return 13;
            default: return 256;
        endcase
    endfunction

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic in_valid = 1'b0;
    logic in_start = 1'b0;
    logic in_last  = 1'b0;
    logic new_bit  = 1'b0;

    always #5 clk = ~clk;

    wire [8:0] rem_o  [NDUT];
    wire [8:0] rrem_o [NDUT];
    wire       divb_o [NDUT];
    wire       done_o [NDUT];
    wire       rdiv_o [NDUT];

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            localparam int D = div_of(g);
            localparam int W = $clog2(D);
            logic [W-1:0] rem;
            logic [W-1:0] rrem;
            logic         dv;
            logic         dn;
            logic         rd;
            serial_remainder_mod_n_fsm #(.DIVISOR(D)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid),
                .in_start   (in_start),
                .in_last    (in_last),
                .new_bit    (new_bit),
                .remainder  (rem),
                .div_by_n   (dv),
                .done       (dn),
                .result_rem (rrem),
                .result_div (rd)
            );
            assign rem_o[g]  = 9'(rem);
            assign rrem_o[g] = 9'(rrem);
            assign divb_o[g] = dv;
            assign done_o[g] = dn;
            assign rdiv_o[g] = rd;
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one cycle of stimulus, then sample just after the edge.
    task automatic step(input logic v, input logic s, input logic l, input logic b);
        in_valid = v;
        in_start = s;
        in_last  = l;
        new_bit  = b;
        @(posedge clk);
        #1;
    endtask

    // Send an integer as one frame in the build's bit order.
    task automatic send_frame(input longint unsigned value, input int len);
        for (int k = 0; k < len; k++) begin
            int idx;
            idx = LSB_FIRST ? k : (len - 1 - k);
            step(1'b1, k == 0, k == len - 1, value[idx]);
        end
    endtask

    typedef struct {
        logic v, s, l, b;
        int   rem;
        logic dn;
        int   rrem;
        logic rdiv;
    } vec_t;

    vec_t            tbl [6];
    longint unsigned p;
    longint unsigned exp_rem [NDUT];
    int              len;
    logic            b;
    logic            last_bit;

    initial begin
        // Post-edge expectations for the divisor-5 instance: value 10.
`ifdef SERIAL_MOD_LSB_FIRST_EN
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 0, 1'b1};
`else
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1};
`endif
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b1};

        // Reset, then one idle cycle.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset n=%0d remainder", div_of(d)), rem_o[d], 0);
            check($sformatf("reset n=%0d div_by_n", div_of(d)), divb_o[d], 1);
            check($sformatf("reset n=%0d done", div_of(d)), done_o[d], 0);
            check($sformatf("reset n=%0d result_rem", div_of(d)), rrem_o[d], 0);
            check($sformatf("reset n=%0d result_div", div_of(d)), rdiv_o[d], 1);
        end

        // Divisor 5, value 10, table driven.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].b);
            check($sformatf("n5 row%0d remainder", i), rem_o[I5], tbl[i].rem);
            check($sformatf("n5 row%0d div_by_n", i), divb_o[I5], tbl[i].rem == 0);
            check($sformatf("n5 row%0d done", i), done_o[I5], tbl[i].dn);
            check($sformatf("n5 row%0d result_rem", i), rrem_o[I5], tbl[i].rrem);
            check($sformatf("n5 row%0d result_div", i), rdiv_o[I5], tbl[i].rdiv);
        end

        // Divisor 7, eight ones (255) with idle gaps carrying stray markers.
        p = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k == 0, k == 7, 1'b1);
            p = (p << 1) | 64'd1;
            check($sformatf("n7 bit%0d remainder", k), rem_o[I7], p % 7);
            check($sformatf("n7 bit%0d done", k), done_o[I7], k == 7);
            for (int gap = 0; gap < k % 3; gap++) begin
                step(1'b0, 1'b1, 1'b1, 1'b0);
                check($sformatf("n7 gap%0d remainder hold", k), rem_o[I7], p % 7);
                check($sformatf("n7 gap%0d done", k), done_o[I7], 0);
            end
        end
        check("n7 result_rem", rrem_o[I7], 3);
        check("n7 result_div", rdiv_o[I7], 0);

        // Divisor 3: single-bit frame, then back-to-back frame 1,1.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("n3 single done", done_o[I3], 1);
        check("n3 single result_rem", rrem_o[I3], 1);
        check("n3 single result_div", rdiv_o[I3], 0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("n3 b2b first done", done_o[I3], 0);
        check("n3 b2b held result_rem", rrem_o[I3], 1);
        check("n3 b2b remainder", rem_o[I3], 1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("n3 b2b last done", done_o[I3], 1);
        check("n3 b2b result_rem", rrem_o[I3], 0);
        check("n3 b2b result_div", rdiv_o[I3], 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("n3 done drops", done_o[I3], 0);

        // Divisor 6: reset while done is high, and reset mid-frame.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("n6 pre-reset done", done_o[I6], 1);
        check("n6 pre-reset result_rem", rrem_o[I6], 3);
        rst = 1'b1;
        #1;
        check("n6 async done", done_o[I6], 0);
        check("n6 async remainder", rem_o[I6], 0);
        check("n6 async result_rem", rrem_o[I6], 0);
        check("n6 async result_div", rdiv_o[I6], 1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("n6 in-reset done", done_o[I6], 0);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("n6 mid-frame remainder", rem_o[I6], LSB_FIRST ? 1 : 2);
        rst = 1'b1;
        #1;
        check("n6 mid-frame async remainder", rem_o[I6], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(64'd6, 3);
        check("n6 new frame done", done_o[I6], 1);
        check("n6 new frame result_rem", rrem_o[I6], 0);
        check("n6 new frame result_div", rdiv_o[I6], 1);

        // Random frames against arithmetic on the framed number.
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) exp_rem[d] = 0;
        for (int f = 0; f < 1000; f++) begin
            len = int'($urandom_range(1, 40));
            p   = 0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    for (int d = 0; d < NDUT; d++) begin
                        check($sformatf("rnd gap n=%0d remainder", div_of(d)), rem_o[d], exp_rem[d]);
                        check($sformatf("rnd gap n=%0d done", div_of(d)), done_o[d], 0);
                    end
                end
                b        = 1'($urandom);
                last_bit = (k == len - 1);
                step(1'b1, k == 0, last_bit, b);
                if (LSB_FIRST) p = p + (longint'(b) << k);
                else           p = (p << 1) | longint'(b);
                for (int d = 0; d < NDUT; d++) begin
                    exp_rem[d] = p % longint'(div_of(d));
                    check($sformatf("rnd f%0d n=%0d remainder", f, div_of(d)), rem_o[d], exp_rem[d]);
                    check($sformatf("rnd f%0d n=%0d div_by_n", f, div_of(d)), divb_o[d], exp_rem[d] == 0);
                    check($sformatf("rnd f%0d n=%0d done", f, div_of(d)), done_o[d], last_bit);
                    if (last_bit) begin
                        check($sformatf("rnd f%0d n=%0d result_rem", f, div_of(d)), rrem_o[d], exp_rem[d]);
                        check($sformatf("rnd f%0d n=%0d result_div", f, div_of(d)), rdiv_o[d], exp_rem[d] == 0);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_remainder_mod_n_fsm
`default_nettype wire
